telem_rx: RTL and testbench
===========================

TELEM_RX -- requirements
Module: telem_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, SHALL set the clk cycles per UART bit period (50 MHz / 19200 baud).
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 RX  input  1  serial telemetry line; idle high; 8N1 framing, LSB first.
REQ-005 batt_v  output  12  battery voltage from the last accepted packet.
REQ-006 avg_curr  output  12  average current from the last accepted packet.
REQ-007 avg_torque  output  12  average torque from the last accepted packet.
REQ-008 pkt_rdy  output  1  one-cycle pulse when all three outputs have updated from a new packet.
REQ-009 frm_err  output  1  one-cycle pulse when a byte's stop bit samples low.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer before any use; all RX timing below is relative to the synchronized signal.
REQ-011 Byte receiver states: IDLE, START, DATA, STOP.
REQ-012 IDLE->START SHALL occur on a synchronized high-to-low RX edge; the bit counter loads BAUD_DIV/2.
REQ-013 START SHALL resample RX at half-bit; if high (glitch) SHALL return to IDLE with no byte and no error; if low SHALL enter DATA with the counter reloaded to BAUD_DIV.
REQ-014 DATA SHALL sample RX once per BAUD_DIV cycles, shifting right into an 8-bit register (LSB first) for exactly 8 samples, then enter STOP.
REQ-015 STOP SHALL sample once more; high -> byte valid for one cycle; low -> frm_err pulse, byte discarded; both SHALL return to IDLE.
REQ-016 Packet parser states: HUNT1, HUNT2, P0..P5.
REQ-017 HUNT1: byte 0xAA -> HUNT2; any other byte -> stay.
REQ-018 HUNT2: 0x55 -> P0; 0xAA -> stay HUNT2; other -> HUNT1.
REQ-019 P0..P5 SHALL capture bytes into shadow registers in order: batt_v[11:8] (byte[3:0]), batt_v[7:0], avg_curr[11:8], avg_curr[7:0], avg_torque[11:8], avg_torque[7:0].
REQ-020 On the valid byte in P5 the parser SHALL copy all shadows to the outputs in one cycle, assert pkt_rdy in the following cycle, and return to HUNT1.
REQ-021 Outputs SHALL never show a mix of values from two packets.
REQ-022 A frm_err in any state SHALL return the parser to HUNT1 and discard all shadows; outputs SHALL hold their prior values.
REQ-023 In P0..P5, payload bytes equal to 0xAA SHALL be treated as data, not resynchronization.
REQ-024 pkt_rdy and frm_err SHALL never assert in the same cycle.

Reset
REQ-025 On rst_n low, both FSMs SHALL enter IDLE/HUNT1 immediately, regardless of the current bit or byte.
REQ-026 On rst_n low, all counters and shadows SHALL clear, batt_v/avg_curr/avg_torque SHALL be 0, and pkt_rdy/frm_err SHALL be 0.
REQ-027 Synchronizer flops SHALL reset to 1 (line idle) so that reset release causes no false start.

Configuration
REQ-028 Macro TELEM_RX_STRICT_PAD_EN: when defined, a high-nibble byte (P0, P2, P4) with nonzero bits [7:4] SHALL pulse frm_err and return the parser to HUNT1.
REQ-029 When TELEM_RX_STRICT_PAD_EN is undefined, bits [7:4] of high-nibble bytes SHALL be ignored and no such check SHALL exist.

Verification
REQ-030 Sequence AA 55 0A BC 01 23 0F FF at BAUD_DIV=16 -> batt_v=0xABC, avg_curr=0x123, avg_torque=0xFFF; exactly one pkt_rdy pulse.
REQ-031 Sequence AA AA 55 00 11 00 22 00 33 -> one packet accepted with values 0x011/0x022/0x033.
REQ-032 Valid packet, then a packet whose 4th byte has a low stop bit -> one frm_err pulse; outputs stay at the first packet's values; no second pkt_rdy.
REQ-033 Low RX glitch of BAUD_DIV/4 cycles in IDLE -> no byte, no frm_err, receiver returns to IDLE.
REQ-034 rst_n asserted midway through P3 -> outputs 0; the next complete packet is accepted normally.
REQ-035 With TELEM_RX_STRICT_PAD_EN defined, AA 55 F1 00 ... -> frm_err pulse, no pkt_rdy; without the macro the same packet is accepted with batt_v=0x100.

Source files
------------

// File: rtl/telem_rx.sv
// Telemetry UART receiver (8N1, LSB first) with AA 55 framed 6-byte packet parser.
// Optional build macro TELEM_RX_STRICT_PAD_EN rejects nonzero pad nibbles in high-nibble bytes.
module telem_rx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic [11:0] batt_v,
   output logic [11:0] avg_curr,
   output logic [11:0] avg_torque,
   output logic        pkt_rdy,
   output logic        frm_err
);

   localparam int CW = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] HUNT1 = 3'd0;
   localparam logic [2:0] HUNT2 = 3'd1;
   localparam logic [2:0] P0    = 3'd2;
   localparam logic [2:0] P1    = 3'd3;
   localparam logic [2:0] P2    = 3'd4;
   localparam logic [2:0] P3    = 3'd5;
   localparam logic [2:0] P4    = 3'd6;
   localparam logic [2:0] P5    = 3'd7;

   logic          rx_s1_reg, rx_s2_reg, rx_prev_reg;
   logic [1:0]    rx_state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          byte_vld_reg, byte_ferr_reg;
   logic          bit_tick;

   logic [2:0]    ps_reg;
   logic [11:0]   sh_batt_reg, sh_curr_reg;
   logic [3:0]    sh_torq_hi_reg;
   logic          pkt_pend_reg;
   logic          pad_err;

   assign bit_tick = (cnt_reg <= CW'(1));

   // Byte receiver; sync flops reset high so reset release never looks like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_reg     <= 1'b1;
         rx_s2_reg     <= 1'b1;
         rx_prev_reg   <= 1'b1;
         rx_state_reg  <= RX_IDLE;
         cnt_reg       <= '0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         byte_vld_reg  <= 1'b0;
         byte_ferr_reg <= 1'b0;
      end else begin
         rx_s1_reg     <= RX;
         rx_s2_reg     <= rx_s1_reg;
         rx_prev_reg   <= rx_s2_reg;
         byte_vld_reg  <= 1'b0;
         byte_ferr_reg <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               if (rx_prev_reg && !rx_s2_reg) begin
                  rx_state_reg <= RX_START;
                  cnt_reg      <= CNT_HALF;
               end
            end
            RX_START: begin
               if (!bit_tick) begin
                  cnt_reg <= cnt_reg - CW'(1);
               end else if (rx_s2_reg) begin
                  rx_state_reg <= RX_IDLE;
               end else begin
                  rx_state_reg <= RX_DATA;
                  cnt_reg      <= CNT_FULL;
                  bit_cnt_reg  <= '0;
               end
            end
            RX_DATA: begin
               if (!bit_tick) begin
                  cnt_reg <= cnt_reg - CW'(1);
               end else begin
                  shift_reg   <= {rx_s2_reg, shift_reg[7:1]};
                  cnt_reg     <= CNT_FULL;
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7)
                     rx_state_reg <= RX_STOP;
               end
            end
            default: begin
               if (!bit_tick) begin
                  cnt_reg <= cnt_reg - CW'(1);
               end else begin
                  if (rx_s2_reg)
                     byte_vld_reg <= 1'b1;
                  else
                     byte_ferr_reg <= 1'b1;
                  rx_state_reg <= RX_IDLE;
               end
            end
         endcase
      end
   end

`ifdef TELEM_RX_STRICT_PAD_EN
   assign pad_err = byte_vld_reg && (shift_reg[7:4] != 4'h0) &&
                    ((ps_reg == P0) || (ps_reg == P2) || (ps_reg == P4));
`else
   assign pad_err = 1'b0;
`endif

   // Packet parser; outputs only change together on the final payload byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_reg         <= HUNT1;
         sh_batt_reg    <= '0;
         sh_curr_reg    <= '0;
         sh_torq_hi_reg <= '0;
         batt_v         <= '0;
         avg_curr       <= '0;
         avg_torque     <= '0;
         pkt_pend_reg   <= 1'b0;
         pkt_rdy        <= 1'b0;
         frm_err        <= 1'b0;
      end else begin
         pkt_pend_reg <= 1'b0;
         pkt_rdy      <= pkt_pend_reg;
         frm_err      <= 1'b0;
         if (byte_ferr_reg || pad_err) begin
            ps_reg         <= HUNT1;
            sh_batt_reg    <= '0;
            sh_curr_reg    <= '0;
            sh_torq_hi_reg <= '0;
            frm_err        <= 1'b1;
         end else if (byte_vld_reg) begin
            case (ps_reg)
               HUNT1: if (shift_reg == 8'hAA) ps_reg <= HUNT2;
               HUNT2: begin
                  if (shift_reg == 8'h55)      ps_reg <= P0;
                  else if (shift_reg != 8'hAA) ps_reg <= HUNT1;
               end
               P0: begin sh_batt_reg[11:8] <= shift_reg[3:0]; ps_reg <= P1; end
               P1: begin sh_batt_reg[7:0]  <= shift_reg;      ps_reg <= P2; end
               P2: begin sh_curr_reg[11:8] <= shift_reg[3:0]; ps_reg <= P3; end
               P3: begin sh_curr_reg[7:0]  <= shift_reg;      ps_reg <= P4; end
               P4: begin sh_torq_hi_reg    <= shift_reg[3:0]; ps_reg <= P5; end
               default: begin
                  batt_v       <= sh_batt_reg;
                  avg_curr     <= sh_curr_reg;
                  avg_torque   <= {sh_torq_hi_reg, shift_reg};
                  pkt_pend_reg <= 1'b1;
                  ps_reg       <= HUNT1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_telem_rx.sv
// Directed bench for telem_rx at BAUD_DIV=16: table of packets plus hand sequences for error/glitch/reset.
module tb_telem_rx;
   localparam int BD = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RX;
   logic [11:0] batt_v, avg_curr, avg_torque;
   logic        pkt_rdy, frm_err;

   int checks = 0;
   int errors = 0;
   int pkt_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;

   telem_rx #(.BAUD_DIV(BD)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX),
      .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
      .pkt_rdy(pkt_rdy), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (pkt_rdy) pkt_cnt++;
         if (frm_err) ferr_cnt++;
         if (pkt_rdy && frm_err) both_cnt++;
      end
   end

   typedef struct {
      logic [95:0] bytes;
      int          n;
      logic [11:0] eb, ec, et;
      int          epkt, eferr;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      RX = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (BD) @(negedge clk);
      end
      RX = stop_bit;
      repeat (BD) @(negedge clk);
      RX = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [63:0] p);
      for (int j = 0; j < 8; j++) send_byte(p[63-8*j -: 8], 1'b1);
   endtask

   initial begin
      int p0, f0;
      logic [63:0] bad;
      vecs[0] = '{96'hAA550ABC01230FFF00000000, 8,  12'hABC, 12'h123, 12'hFFF, 1, 0};
      vecs[1] = '{96'hAAAA55001100220033000000, 9,  12'h011, 12'h022, 12'h033, 1, 0};
      vecs[2] = '{96'hAA5501AA02AA03AA00000000, 8,  12'h1AA, 12'h2AA, 12'h3AA, 1, 0};
      vecs[3] = '{96'h12AA34AA550567089A0CDE00, 11, 12'h567, 12'h89A, 12'hCDE, 1, 0};
`ifdef TELEM_RX_STRICT_PAD_EN
      vecs[4] = '{96'hAA55F100F200F30000000000, 8,  12'h567, 12'h89A, 12'hCDE, 0, 1};
`else
      vecs[4] = '{96'hAA55F100F200F30000000000, 8,  12'h100, 12'h200, 12'h300, 1, 0};
`endif

      RX = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_batt", 32'(batt_v), 32'h0);
      check("rst_curr", 32'(avg_curr), 32'h0);
      check("rst_torq", 32'(avg_torque), 32'h0);
      check("rst_pkt_rdy", 32'(pkt_rdy), 32'h0);
      check("rst_frm_err", 32'(frm_err), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         p0 = pkt_cnt;
         f0 = ferr_cnt;
         for (int j = 0; j < vecs[i].n; j++)
            send_byte(vecs[i].bytes[95-8*j -: 8], 1'b1);
         repeat (10) @(negedge clk);
         $display("vec %0d: batt=%h curr=%h torq=%h pkts=%0d ferrs=%0d", i, batt_v, avg_curr,
                  avg_torque, pkt_cnt - p0, ferr_cnt - f0);
         check($sformatf("v%0d_batt", i), 32'(batt_v), 32'(vecs[i].eb));
         check($sformatf("v%0d_curr", i), 32'(avg_curr), 32'(vecs[i].ec));
         check($sformatf("v%0d_torq", i), 32'(avg_torque), 32'(vecs[i].et));
         check($sformatf("v%0d_pkts", i), 32'(pkt_cnt - p0), 32'(vecs[i].epkt));
         check($sformatf("v%0d_ferrs", i), 32'(ferr_cnt - f0), 32'(vecs[i].eferr));
      end

      // Good packet, then a packet whose 4th byte has a low stop bit
      p0 = pkt_cnt;
      f0 = ferr_cnt;
      send_pkt(64'hAA550ABC01230FFF);
      bad = 64'hAA55010203040506;
      for (int j = 0; j < 8; j++) send_byte(bad[63-8*j -: 8], (j == 3) ? 1'b0 : 1'b1);
      repeat (10) @(negedge clk);
      $display("frame-error seq: batt=%h curr=%h torq=%h pkts=%0d ferrs=%0d", batt_v, avg_curr,
               avg_torque, pkt_cnt - p0, ferr_cnt - f0);
      check("ferr_batt", 32'(batt_v), 32'hABC);
      check("ferr_curr", 32'(avg_curr), 32'h123);
      check("ferr_torq", 32'(avg_torque), 32'hFFF);
      check("ferr_pkts", 32'(pkt_cnt - p0), 32'd1);
      check("ferr_ferrs", 32'(ferr_cnt - f0), 32'd1);

      // Short low glitch in idle, then a normal packet must still decode
      p0 = pkt_cnt;
      f0 = ferr_cnt;
      RX = 1'b0;
      repeat (BD / 4) @(negedge clk);
      RX = 1'b1;
      repeat (3 * BD) @(negedge clk);
      $display("glitch: pkts=%0d ferrs=%0d", pkt_cnt - p0, ferr_cnt - f0);
      check("glitch_ferrs", 32'(ferr_cnt - f0), 32'd0);
      check("glitch_pkts", 32'(pkt_cnt - p0), 32'd0);
      send_pkt(64'hAA55034506780 * 0 + 64'hAA550345067809_9A);
      repeat (10) @(negedge clk);
      $display("post-glitch pkt: batt=%h curr=%h torq=%h", batt_v, avg_curr, avg_torque);
      check("glitch_batt", 32'(batt_v), 32'h345);
      check("glitch_curr", 32'(avg_curr), 32'h678);
      check("glitch_torq", 32'(avg_torque), 32'h99A);
      check("glitch_pkts2", 32'(pkt_cnt - p0), 32'd1);

      // Reset asserted in the middle of the P3 byte
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h0A, 1'b1);
      send_byte(8'hBC, 1'b1);
      send_byte(8'h01, 1'b1);
      RX = 1'b0;
      repeat (3 * BD) @(negedge clk);
      rst_n = 1'b0;
      RX = 1'b1;
      repeat (3) @(negedge clk);
      $display("mid-P3 reset: batt=%h curr=%h torq=%h", batt_v, avg_curr, avg_torque);
      check("midrst_batt", 32'(batt_v), 32'h0);
      check("midrst_curr", 32'(avg_curr), 32'h0);
      check("midrst_torq", 32'(avg_torque), 32'h0);
      check("midrst_pkt_rdy", 32'(pkt_rdy), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      p0 = pkt_cnt;
      f0 = ferr_cnt;
      send_pkt(64'hAA550FED0CBA0987);
      repeat (10) @(negedge clk);
      $display("post-reset pkt: batt=%h curr=%h torq=%h pkts=%0d", batt_v, avg_curr, avg_torque,
               pkt_cnt - p0);
      check("postrst_batt", 32'(batt_v), 32'hFED);
      check("postrst_curr", 32'(avg_curr), 32'hCBA);
      check("postrst_torq", 32'(avg_torque), 32'h987);
      check("postrst_pkts", 32'(pkt_cnt - p0), 32'd1);
      check("postrst_ferrs", 32'(ferr_cnt - f0), 32'd0);

      check("pkt_and_ferr_same_cycle", 32'(both_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
